pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and data-memory handshake control for a 5-stage RISC-V pipeline.
// Optional feature: define PIPE_STALL_CNT_EN to enable the saturating StallCycles counter.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rs1_D, rs2_D        source registers of the instruction in Decode
//   rd_E, ResultSrc_E   destination and result select in Execute (2'b01 = load)
//   PCSrc_E             taken branch/jump resolved in Execute
//   MemReq_M, MemReady  data-memory request from Memory stage; completion strobe
//   MemValid            access request presented to data memory
//   StallF..StallM      hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD, FlushE      bubble IF/ID, ID/EX
//   FlushW              bubble MEM/WB (kills RegWrite_W)
//   MemErr              sticky data-memory timeout error
//   StallCycles         cycles spent with StallF=1 (0 unless PIPE_STALL_CNT_EN)

module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic [4:0]  rd_E,
    input  logic [1:0]  ResultSrc_E,
    input  logic        PCSrc_E,
    input  logic        MemReq_M,
    input  logic        MemReady,
    output logic        MemValid,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemErr,
    output logic [31:0] StallCycles
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nx;
    logic       mem_stall;
    logic       mem_valid_raw;
    logic       load_use;

    assign load_use = (ResultSrc_E == 2'b01) && (rd_E != 5'd0) &&
                      ((rd_E == rs1_D) || (rd_E == rs2_D));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // Memory handshake: next state, wait counter and the raw memory stall.
    always_comb begin
        state_nx      = state;
        wait_cnt_nx   = wait_cnt;
        mem_valid_raw = 1'b0;
        mem_stall     = 1'b0;
        unique case (state)
            IDLE: begin
                if (MemReq_M) begin
                    mem_valid_raw = 1'b1;
                    if (!MemReady) begin
                        mem_stall   = 1'b1;
                        state_nx    = WAIT;
                        wait_cnt_nx = 8'd1;
                    end
                end
            end
            WAIT: begin
                // Request is held here even if MemReq_M drops; only
                // MemReady retires the access.
                mem_valid_raw = 1'b1;
                if (MemReady) begin
                    state_nx    = IDLE;
                    wait_cnt_nx = 8'd0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt == TIMEOUT) begin
                        state_nx = ERR;
                    end else begin
                        wait_cnt_nx = wait_cnt + 8'd1;
                    end
                end
            end
            ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_nx    = IDLE;
                wait_cnt_nx = 8'd0;
            end
        endcase
    end

    // Stall/flush priority: reset, then memory stall, then redirect,
    // then load-use. A branch held by a memory stall flushes once the
    // stall releases, since it is still sitting in Execute.
    always_comb begin
        MemValid = 1'b0;
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushW   = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            MemValid = mem_valid_raw;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrc_E) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign MemErr = (state == ERR);

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (StallF && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign StallCycles = stall_cnt;
`else
    assign StallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed + randomized check of pipeline_ctrl
// against a transaction-level reference model.

module tb_pipeline_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_D;
    logic [4:0]  rs2_D;
    logic [4:0]  rd_E;
    logic [1:0]  ResultSrc_E;
    logic        PCSrc_E;
    logic        MemReq_M;
    logic        MemReady;
    logic        MemValid;
    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        StallM;
    logic        FlushD;
    logic        FlushE;
    logic        FlushW;
    logic        MemErr;
    logic [31:0] StallCycles;

    pipeline_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_D       (rs1_D),
        .rs2_D       (rs2_D),
        .rd_E        (rd_E),
        .ResultSrc_E (ResultSrc_E),
        .PCSrc_E     (PCSrc_E),
        .MemReq_M    (MemReq_M),
        .MemReady    (MemReady),
        .MemValid    (MemValid),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .MemErr      (MemErr),
        .StallCycles (StallCycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: an access is outstanding or not, how many stall
    // cycles it has accumulated, and whether it has timed out.
    bit          m_pend = 1'b0;
    bit          m_err  = 1'b0;
    int          m_stalls = 0;
    logic [31:0] m_cnt = 32'd0;

`ifdef PIPE_STALL_CNT_EN
    localparam logic [31:0] EXP10 = 32'd10;
`else
    localparam logic [31:0] EXP10 = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic r,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [1:0] rs,
                       input logic pc, input logic mq, input logic mr);
        logic lu, busy, ms;
        logic v, sf, sd, se, sm, fd, fe, fw;
        rst = r; rs1_D = a; rs2_D = b; rd_E = d; ResultSrc_E = rs;
        PCSrc_E = pc; MemReq_M = mq; MemReady = mr;
        @(negedge clk);
        lu   = (rs == 2'b01) && (d != 5'd0) && (d == a || d == b);
        busy = !m_err && (m_pend || mq);
        ms   = m_err || (busy && !mr);
        {v, sf, sd, se, sm, fd, fe, fw} = '0;
        if (r) begin
            fd = 1; fe = 1; fw = 1;
        end else begin
            v = busy;
            if (ms) begin
                sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
            end else if (pc) begin
                fd = 1; fe = 1;
            end else if (lu) begin
                sf = 1; sd = 1; fe = 1;
            end
        end
        check({tag, ".ctl"},
              {23'd0, MemValid, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, MemErr},
              {23'd0, v, sf, sd, se, sm, fd, fe, fw, m_err});
        check({tag, ".cnt"}, StallCycles, m_cnt);
        if (r) begin
            m_pend = 0; m_err = 0; m_stalls = 0; m_cnt = 32'd0;
        end else begin
            if (busy) begin
                if (mr) begin
                    m_pend = 0; m_stalls = 0;
                end else begin
                    m_stalls++;
                    m_pend = 1;
                    // first stall is in IDLE, then T waits are allowed
                    if (m_stalls > T) begin
                        m_err = 1; m_pend = 0;
                    end
                end
            end
`ifdef PIPE_STALL_CNT_EN
            if (sf && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic mr);
        cyc(tag, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, mr);
    endtask

    initial begin
        int ready_pct;
        rst = 1; rs1_D = 0; rs2_D = 0; rd_E = 0; ResultSrc_E = 0;
        PCSrc_E = 0; MemReq_M = 0; MemReady = 0;
        repeat (2) @(posedge clk);
        #1;

        cyc("reset", 1, 0, 0, 0, 2'b00, 0, 1, 0);
        idle("idle", 0);

        cyc("loaduse", 0, 5'd5, 5'd0, 5'd5, 2'b01, 0, 0, 0);
        cyc("lu_rs2", 0, 5'd1, 5'd7, 5'd7, 2'b01, 0, 0, 0);
        cyc("lu_x0", 0, 5'd0, 5'd0, 5'd0, 2'b01, 0, 0, 0);
        cyc("br_lu", 0, 5'd5, 5'd0, 5'd5, 2'b01, 1, 0, 0);
        cyc("zerowait", 0, 0, 0, 0, 2'b00, 0, 1, 1);

        for (int i = 0; i < 3; i++)
            cyc("wait3", 0, 5'd5, 0, 5'd5, 2'b01, 1, 1, 0);
        cyc("release", 0, 5'd5, 0, 5'd5, 2'b01, 1, 0, 1);
        idle("after", 0);

        cyc("to_req", 0, 0, 0, 0, 2'b00, 0, 1, 0);
        for (int i = 0; i < T; i++) idle("to_wait", 0);
        for (int i = 0; i < 3; i++) cyc("err", 0, 0, 0, 0, 2'b00, 1, 1, 1);
        check("memerr", {31'd0, MemErr}, 32'd1);
        cyc("err_rst", 1, 0, 0, 0, 2'b00, 0, 0, 0);

        cyc("w_req", 0, 0, 0, 0, 2'b00, 0, 1, 0);
        idle("w_hold", 0);
        cyc("w_rst", 1, 0, 0, 0, 2'b00, 0, 1, 0);
        idle("w_after", 0);

        cyc("cnt_rst", 1, 0, 0, 0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc("lu10", 0, 5'd3, 5'd9, 5'd9, 2'b01, 0, 0, 0);
        check("stall10", StallCycles, EXP10);

        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            if (i % 200 == 0) ready_pct = (ready_pct == 50) ? 15 : 50;
            r = m_err ? ($urandom_range(0, 7) == 0)
                      : ($urandom_range(0, 99) == 0);
            cyc("rand", r,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 99) < ready_pct));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
